stopwatch_lap_timer: RTL and testbench
======================================

Name: stopwatch_lap_timer

Overview:
Parametrised successor to the team's single-mode stopwatch. It is a BCD mm:ss.hh timer with count-up or countdown mode, a lap/clear button, and a LAP_DEPTH-entry lap store that can be recalled onto the display. It is driven by pushbutton inputs with synchronisation and debounce, and feeds six active-low seven-segment digits on the board.

Parameters:
CLK_FREQ_HZ, 50_000_000, input clock frequency; tick divider DIV = CLK_FREQ_HZ/100 (must be an integer ≥1).
LAP_DEPTH, 8, number of stored lap times (≥1).
DEBOUNCE_CYCLES, 500_000, cycles a synchronised button must be stable before it is accepted; 0 = bypass.

Ports:
CLK_50MHz  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
start_stop  in  1  active-low pushbutton: start/stop.
lap_n  in  1  active-low pushbutton: lap when running, clear when stopped.
recall_n  in  1  active-low pushbutton: step the displayed lap.
count_down  in  1  mode level: 1 = countdown; sampled only in STOPPED.
preset_bcd  in  24  countdown start value {m10,m1,s10,s1,t,h}, 4 bits each.
time_bcd  out  24  live counter value, same packing.
seg_out  out  42  {m10,m1,s10,s1,t,h} of the displayed value, 7 bits each, gfedcba, active-low.
CLK_ind  out  1  toggles on every 100 Hz tick.
running  out  1  high in RUNNING.
overflow_flag  out  1  sticky count-up wrap indicator.
done  out  1  high in DONE.
lap_count  out  $clog2(LAP_DEPTH+1)  number of laps stored.
lap_full  out  1  lap_count == LAP_DEPTH.
showing_lap  out  1  high when seg_out shows a stored lap instead of the live value.

Behaviour:
- Reset (async assert, sync release): state STOPPED, time 0, laps cleared, display index = live. All outputs 0 except seg_out = six copies of 7'b1000000 ("0").
- Buttons: 2-flop synchroniser, then debounce (stable for DEBOUNCE_CYCLES cycles), then 1→0 edge detect giving a 1-cycle event. With DEBOUNCE_CYCLES=0 the event fires 3 cycles after the pin falls.
- Prescaler: counts 0..DIV-1 only in RUNNING; tick at DIV-1. It is zeroed on entry to RUNNING, so the first tick comes DIV cycles after the start event.
- Digit limits: h and t 0-9, s1 0-9, s10 0-5, m1 0-9, m10 0-9. Carry and borrow ripple within the tick cycle.
- FSM states: STOPPED, RUNNING, DONE.
  - STOPPED + start event: latch count_down and go to RUNNING. Exception: countdown mode with time == 0 stays in STOPPED.
  - RUNNING + start event: go to STOPPED. Time is held.
  - STOPPED + lap event (clear): time ← 0 in up mode, or ← preset in down mode. Also clears laps, overflow_flag and display index.
  - DONE + lap event: same clear as above, then go to STOPPED. Start events in DONE are ignored.
- Count-up: 99:59.99 + tick → 00:00.00, overflow_flag set (sticky), keeps RUNNING.
- Countdown: tick at 00:00.01 → 00:00.00, go to DONE.
- Countdown borrow: 10:00.00 → 09:59.99.
- Preset coercion: any digit >9 loads as 9; s10 >5 loads as 5.
- Lap event in RUNNING:
  - Stores the current registered time_bcd (the pre-tick value if a tick occurs in the same cycle) at index lap_count, then lap_count++.
  - When lap_full, the event is dropped and the store is unchanged.
- Recall event (any state):
  - Ignored when lap_count = 0.
  - Otherwise the index advances live → lap0 → … → lap(lap_count-1) → live.
  - showing_lap = 1 whenever index ≠ live. Counting continues in the background.
- Same-cycle events: start_stop wins; a lap event in that cycle is discarded. Recall is processed independently.
- Output timing: time_bcd, flags and state are registered. seg_out is a combinational decode of the selected value.
- Reset mid-operation: immediate return to the reset values above; lap store contents become don't-care, with lap_count = 0.

Test Plan:
- CLK_FREQ_HZ=10_000, DEBOUNCE_CYCLES=0. Reset, then start pulse, then wait 250×100 cycles → time_bcd = 00:02.50, running=1, and CLK_ind has toggled 250 times. Stop → the value holds for 1000 further cycles.
- CLK_FREQ_HZ=100 (DIV=1). Start, run 600_000 ticks → time wraps 99:59.99 → 00:00.00, overflow_flag=1, running=1. Lap press while stopped → overflow_flag=0, time 0.
- count_down=1, preset 00:01.00, lap (clear) then start. After 100 ticks → time 00:00.00, done=1, running=0. Start press → no change. Lap → STOPPED with time 00:01.00.
- LAP_DEPTH=4, running. 5 lap presses at known times → lap_count=4, lap_full=1, fifth press dropped. Recall ×5 → seg_out shows lap0..lap3, then live; showing_lap = 1,1,1,1,0.
- Start and lap events in the same cycle while RUNNING → STOPPED, lap_count unchanged.
- reset_n low mid-tick while RUNNING with laps stored → all outputs return to reset values within the same cycle, lap_count=0.

Source files
------------

// File: rtl/stopwatch_lap_timer_if.sv
// rtl/stopwatch_lap_timer_if.sv - buttons, mode, preset and display signals of the lap timer
interface stopwatch_lap_timer_if #(
    parameter int LAP_DEPTH = 8
);
    localparam int LC_W = $clog2(LAP_DEPTH + 1);

    logic            start_stop;
    logic            lap_n;
    logic            recall_n;
    logic            count_down;
    logic [23:0]     preset_bcd;
    logic [23:0]     time_bcd;
    logic [41:0]     seg_out;
    logic            CLK_ind;
    logic            running;
    logic            overflow_flag;
    logic            done;
    logic [LC_W-1:0] lap_count;
    logic            lap_full;
    logic            showing_lap;

    modport master (
        output start_stop, lap_n, recall_n, count_down, preset_bcd,
        input  time_bcd, seg_out, CLK_ind, running, overflow_flag, done,
               lap_count, lap_full, showing_lap
    );

    modport slave (
        input  start_stop, lap_n, recall_n, count_down, preset_bcd,
        output time_bcd, seg_out, CLK_ind, running, overflow_flag, done,
               lap_count, lap_full, showing_lap
    );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// rtl/stopwatch_lap_timer.sv - BCD mm:ss.hh up/down stopwatch with lap store and 7-seg output
module stopwatch_lap_timer #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int LAP_DEPTH       = 8,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                 CLK_50MHz,
    input  logic                 reset_n,
    stopwatch_lap_timer_if.slave bus
);
    localparam int DIV  = CLK_FREQ_HZ / 100;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LC_W = $clog2(LAP_DEPTH + 1);
    localparam int AW   = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {S_STOPPED, S_RUNNING, S_DONE} state_t;

    // digit order inside a 24-bit value, LSB first: h, t, s1, s10, m1, m10
    function automatic logic [3:0] digit_limit(input int i);
        return (i == 3) ? 4'd5 : 4'd9;
    endfunction

    // increment with ripple carry; MSB of the result is the wrap-out
    function automatic logic [24:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (v[4*i +: 4] == digit_limit(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // decrement with ripple borrow; only used while the value is nonzero
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = digit_limit(i);
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // clamp out-of-range preset digits to their maximum legal value
    function automatic logic [23:0] coerce(input logic [23:0] v);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > digit_limit(i)) ? digit_limit(i) : v[4*i +: 4];
        end
        return r;
    endfunction

    // gfedcba, active-low
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // button bit order: 0 start_stop, 1 lap, 2 recall
    logic [2:0] btn_raw, btn_sync1, btn_sync2, btn_db, btn_prev, btn_ev;

    assign btn_raw = {bus.recall_n, bus.lap_n, bus.start_stop};

    // two-flop synchroniser and debounced-level history; idle level of a button is high
    always_ff @(posedge CLK_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync1 <= '1;
            btn_sync2 <= '1;
            btn_prev  <= '1;
        end else begin
            btn_sync1 <= btn_raw;
            btn_sync2 <= btn_sync1;
            btn_prev  <= btn_db;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_db
            assign btn_db = btn_sync2;
        end else begin : g_db
            for (genvar i = 0; i < 3; i++) begin : g_btn
                logic [DB_W-1:0] cnt;
                logic            stable;
                // accept a new level only after it has persisted DEBOUNCE_CYCLES cycles
                always_ff @(posedge CLK_50MHz or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt    <= '0;
                        stable <= 1'b1;
                    end else if (btn_sync2[i] == stable) begin
                        cnt <= '0;
                    end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        cnt    <= '0;
                        stable <= btn_sync2[i];
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                assign btn_db[i] = stable;
            end
        end
    endgenerate

    // press = debounced 1->0 transition, one cycle wide
    assign btn_ev = btn_prev & ~btn_db;

    state_t          state_q, state_d;
    logic [23:0]     time_q, time_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            mode_q, mode_d;
    logic            ovf_q, ovf_d;
    logic            clk_ind_q, clk_ind_d;
    logic [LC_W-1:0] lap_cnt_q, lap_cnt_d;
    logic            show_q, show_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            lap_we;
    logic [23:0]     lap_mem [LAP_DEPTH];

    logic            ev_start, ev_lap, ev_recall, tick, lap_full_w, do_clear;
    logic [24:0]     inc_val;
    logic [23:0]     dec_val;

    assign ev_start   = btn_ev[0];
    assign ev_lap     = btn_ev[1] & ~btn_ev[0];
    assign ev_recall  = btn_ev[2];
    assign tick       = (state_q == S_RUNNING) && (presc_q == PW'(DIV - 1));
    assign lap_full_w = (lap_cnt_q == LC_W'(LAP_DEPTH));
    assign inc_val    = bcd_inc(time_q);
    assign dec_val    = bcd_dec(time_q);

    // next-state logic: recall stepping, mode FSM, counting, lap capture, clear
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        presc_d   = presc_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        clk_ind_d = clk_ind_q;
        lap_cnt_d = lap_cnt_q;
        show_d    = show_q;
        idx_d     = idx_q;
        lap_we    = 1'b0;
        do_clear  = 1'b0;

        if (ev_recall && lap_cnt_q != '0) begin
            if (!show_q) begin
                show_d = 1'b1;
                idx_d  = '0;
            end else if (LC_W'(idx_q) == lap_cnt_q - LC_W'(1)) begin
                show_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end

        case (state_q)
            S_STOPPED: begin
                if (ev_start) begin
                    if (!(bus.count_down && time_q == '0)) begin
                        state_d = S_RUNNING;
                        mode_d  = bus.count_down;
                        presc_d = '0;
                    end
                end else if (ev_lap) begin
                    do_clear = 1'b1;
                end
            end
            S_RUNNING: begin
                if (ev_lap && !lap_full_w) begin
                    lap_we    = 1'b1;
                    lap_cnt_d = lap_cnt_q + LC_W'(1);
                end
                if (tick) begin
                    presc_d   = '0;
                    clk_ind_d = ~clk_ind_q;
                    if (mode_q) begin
                        time_d = dec_val;
                        if (dec_val == '0) state_d = S_DONE;
                    end else begin
                        time_d = inc_val[23:0];
                        if (inc_val[24]) ovf_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (ev_start) state_d = S_STOPPED;
            end
            S_DONE: begin
                if (ev_lap) begin
                    do_clear = 1'b1;
                    state_d  = S_STOPPED;
                end
            end
            default: state_d = S_STOPPED;
        endcase

        if (do_clear) begin
            time_d    = bus.count_down ? coerce(bus.preset_bcd) : 24'd0;
            lap_cnt_d = '0;
            ovf_d     = 1'b0;
            show_d    = 1'b0;
            idx_d     = '0;
        end
    end

    // state and counter registers
    always_ff @(posedge CLK_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_STOPPED;
            time_q    <= '0;
            presc_q   <= '0;
            mode_q    <= 1'b0;
            ovf_q     <= 1'b0;
            clk_ind_q <= 1'b0;
            lap_cnt_q <= '0;
            show_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            clk_ind_q <= clk_ind_d;
            lap_cnt_q <= lap_cnt_d;
            show_q    <= show_d;
            idx_q     <= idx_d;
        end
    end

    // lap store; contents are don't-care after reset, lap_cnt_q alone says what is valid
    always_ff @(posedge CLK_50MHz) begin
        if (lap_we) lap_mem[lap_cnt_q[AW-1:0]] <= time_q;
    end

    logic [23:0] disp;
    assign disp = show_q ? lap_mem[idx_q] : time_q;

    // combinational seven-segment decode of the selected value
    always_comb begin
        bus.seg_out = '1;
        for (int i = 0; i < 6; i++) begin
            bus.seg_out[7*i +: 7] = seg7(disp[4*i +: 4]);
        end
    end

    assign bus.time_bcd      = time_q;
    assign bus.CLK_ind       = clk_ind_q;
    assign bus.running       = (state_q == S_RUNNING);
    assign bus.done          = (state_q == S_DONE);
    assign bus.overflow_flag = ovf_q;
    assign bus.lap_count     = lap_cnt_q;
    assign bus.lap_full      = lap_full_w;
    assign bus.showing_lap   = show_q;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb/tb_stopwatch_lap_timer.sv - randomized self-checking bench for stopwatch_lap_timer
module tb_stopwatch_lap_timer;
    localparam int CLK_HZ  = 1000;
    localparam int DIV     = CLK_HZ / 100;
    localparam int DEPTH   = 4;
    localparam int MAX_CS  = 599999;
    localparam int ST_STOP = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;
    localparam bit [2:0] B_START  = 3'b001;
    localparam bit [2:0] B_LAP    = 3'b010;
    localparam bit [2:0] B_RECALL = 3'b100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stopwatch_lap_timer_if #(.LAP_DEPTH(DEPTH)) sw ();

    stopwatch_lap_timer #(
        .CLK_FREQ_HZ(CLK_HZ),
        .LAP_DEPTH(DEPTH),
        .DEBOUNCE_CYCLES(0)
    ) dut (
        .CLK_50MHz(clk),
        .reset_n(rst_n),
        .bus(sw)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_state, m_cs, m_presc, m_idx;
    bit m_mode, m_ovf, m_clk;
    int m_laps[$];
    bit [2:0] h1, h2, h3;

    // centiseconds -> packed BCD mm:ss.hh
    function automatic logic [23:0] to_bcd(input int cs);
        int mm, ss, cc;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic int coerce_cs(input logic [23:0] p);
        int d[6];
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(p[4*i +: 4]);
            if (d[i] > 9) d[i] = 9;
        end
        if (d[3] > 5) d[3] = 5;
        return (d[5] * 10 + d[4]) * 6000 + (d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
    endfunction

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] exp_seg();
        logic [23:0] v;
        logic [41:0] s;
        v = to_bcd((m_idx < 0) ? m_cs : m_laps[m_idx]);
        for (int i = 0; i < 6; i++) s[7*i +: 7] = seg7(int'(v[4*i +: 4]));
        return s;
    endfunction

    task automatic model_reset();
        m_state = ST_STOP; m_cs = 0; m_presc = 0; m_idx = -1;
        m_mode = 0; m_ovf = 0; m_clk = 0;
        m_laps.delete();
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_clear();
        m_cs  = sw.count_down ? coerce_cs(sw.preset_bcd) : 0;
        m_laps.delete();
        m_ovf = 0;
        m_idx = -1;
    endtask

    // one clock edge of the timer's rules applied to the bench-side state
    task automatic model_edge(input bit [2:0] ev);
        bit es, el, er, tk;
        int nl;
        es = ev[0];
        el = ev[1] & ~ev[0];
        er = ev[2];
        nl = m_laps.size();
        tk = (m_state == ST_RUN) && (m_presc == DIV - 1);
        if (er && nl > 0) m_idx = (m_idx == nl - 1) ? -1 : m_idx + 1;
        case (m_state)
            ST_STOP: begin
                if (es) begin
                    if (!(sw.count_down && m_cs == 0)) begin
                        m_state = ST_RUN; m_mode = sw.count_down; m_presc = 0;
                    end
                end else if (el) begin
                    model_clear();
                end
            end
            ST_RUN: begin
                if (el && nl < DEPTH) m_laps.push_back(m_cs);
                if (tk) begin
                    m_clk = ~m_clk;
                    m_presc = 0;
                    if (m_mode) begin
                        m_cs = m_cs - 1;
                        if (m_cs == 0) m_state = ST_DONE;
                    end else if (m_cs == MAX_CS) begin
                        m_cs = 0; m_ovf = 1;
                    end else begin
                        m_cs = m_cs + 1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
                if (es) m_state = ST_STOP;
            end
            default: begin
                if (el) begin
                    model_clear();
                    m_state = ST_STOP;
                end
            end
        endcase
    endtask

    // drive one cycle of button requests (a requested pin is low for this cycle)
    task automatic step(input bit [2:0] req);
        sw.start_stop = ~req[0];
        sw.lap_n      = ~req[1];
        sw.recall_n   = ~req[2];
        @(posedge clk);
        model_edge(h2 & ~h3);
        h3 = h2; h2 = h1; h1 = req;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000);
    endtask

    task automatic press(input bit [2:0] b);
        step(b);
        idle(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sw.start_stop = 1'b1; sw.lap_n = 1'b1; sw.recall_n = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [41:0] zero_seg;
        zero_seg = {6{7'b1000000}};
        sw.count_down = 1'b0;
        sw.preset_bcd = 24'h0;
        do_reset();
        total++; if (sw.time_bcd !== 24'h0) begin bad++; $display("FAIL reset_time got=%h exp=000000", sw.time_bcd); end
        total++; if (sw.seg_out !== zero_seg) begin bad++; $display("FAIL reset_seg got=%h exp=%h", sw.seg_out, zero_seg); end
        total++; if ({sw.running, sw.done, sw.overflow_flag, sw.CLK_ind, sw.lap_full, sw.showing_lap} !== 6'b0)
            begin bad++; $display("FAIL reset_flags got=%b exp=000000", {sw.running, sw.done, sw.overflow_flag, sw.CLK_ind, sw.lap_full, sw.showing_lap}); end
        total++; if (sw.lap_count !== 3'd0) begin bad++; $display("FAIL reset_lap_count got=%0d exp=0", sw.lap_count); end
    endtask

    task automatic test_count_up();
        int toggles;
        logic prev;
        logic [23:0] exp;
        toggles = 0;
        prev = sw.CLK_ind;
        press(B_START);
        for (int i = 0; i < 250 * DIV; i++) begin
            step(3'b000);
            if (sw.CLK_ind !== prev) toggles++;
            prev = sw.CLK_ind;
        end
        total++; if (sw.time_bcd !== 24'h000250) begin bad++; $display("FAIL up_time got=%h exp=000250", sw.time_bcd); end
        total++; if (sw.running !== 1'b1) begin bad++; $display("FAIL up_running got=%b exp=1", sw.running); end
        total++; if (toggles != 250) begin bad++; $display("FAIL up_clk_ind toggles got=%0d exp=250", toggles); end
        press(B_START);
        exp = to_bcd(m_cs);
        idle(1000);
        total++; if (sw.time_bcd !== exp) begin bad++; $display("FAIL stop_hold got=%h exp=%h", sw.time_bcd, exp); end
        total++; if (sw.running !== 1'b0) begin bad++; $display("FAIL stop_running got=%b exp=0", sw.running); end
    endtask

    task automatic test_wrap();
        sw.count_down = 1'b1;
        sw.preset_bcd = 24'h9F79C0;
        press(B_LAP);
        total++; if (sw.time_bcd !== 24'h995990) begin bad++; $display("FAIL preset_coerce got=%h exp=995990", sw.time_bcd); end
        sw.count_down = 1'b0;
        press(B_START);
        idle(10 * DIV + 3 * DIV);
        total++; if (sw.time_bcd !== 24'h000003) begin bad++; $display("FAIL wrap_time got=%h exp=000003", sw.time_bcd); end
        total++; if (sw.overflow_flag !== 1'b1 || sw.running !== 1'b1)
            begin bad++; $display("FAIL wrap_flags got ovf=%b run=%b exp ovf=1 run=1", sw.overflow_flag, sw.running); end
        press(B_START);
        press(B_LAP);
        total++; if (sw.overflow_flag !== 1'b0 || sw.time_bcd !== 24'h0)
            begin bad++; $display("FAIL wrap_clear got ovf=%b time=%h exp ovf=0 time=000000", sw.overflow_flag, sw.time_bcd); end
    endtask

    task automatic test_countdown();
        sw.count_down = 1'b1;
        sw.preset_bcd = 24'h000100;
        press(B_LAP);
        press(B_START);
        idle(100 * DIV);
        total++; if (sw.time_bcd !== 24'h0 || sw.done !== 1'b1 || sw.running !== 1'b0)
            begin bad++; $display("FAIL down_done got time=%h done=%b run=%b exp 000000 1 0", sw.time_bcd, sw.done, sw.running); end
        press(B_START);
        idle(3);
        total++; if (sw.done !== 1'b1 || sw.time_bcd !== 24'h0)
            begin bad++; $display("FAIL done_ignores_start got done=%b time=%h exp 1 000000", sw.done, sw.time_bcd); end
        press(B_LAP);
        total++; if (sw.done !== 1'b0 || sw.running !== 1'b0 || sw.time_bcd !== 24'h000100)
            begin bad++; $display("FAIL done_clear got done=%b run=%b time=%h exp 0 0 000100", sw.done, sw.running, sw.time_bcd); end
        sw.preset_bcd = 24'h100000;
        press(B_LAP);
        press(B_START);
        idle(DIV);
        total++; if (sw.time_bcd !== 24'h095999) begin bad++; $display("FAIL down_borrow got=%h exp=095999", sw.time_bcd); end
        press(B_START);
        sw.preset_bcd = 24'h0;
        press(B_LAP);
        press(B_START);
        total++; if (sw.running !== 1'b0) begin bad++; $display("FAIL down_zero_start got run=%b exp=0", sw.running); end
    endtask

    task automatic test_laps();
        bit exp_show[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [41:0] es;
        sw.count_down = 1'b0;
        press(B_LAP);
        press(B_START);
        for (int k = 0; k < 5; k++) begin
            idle($urandom_range(3, 40));
            press(B_LAP);
            total++; if (sw.lap_count !== 3'((k < DEPTH) ? k + 1 : DEPTH))
                begin bad++; $display("FAIL lap_count[%0d] got=%0d exp=%0d", k, sw.lap_count, (k < DEPTH) ? k + 1 : DEPTH); end
        end
        total++; if (sw.lap_full !== 1'b1) begin bad++; $display("FAIL lap_full got=%b exp=1", sw.lap_full); end
        for (int k = 0; k < 5; k++) begin
            press(B_RECALL);
            es = exp_seg();
            total++; if (sw.showing_lap !== exp_show[k])
                begin bad++; $display("FAIL recall_show[%0d] got=%b exp=%b", k, sw.showing_lap, exp_show[k]); end
            total++; if (sw.seg_out !== es)
                begin bad++; $display("FAIL recall_seg[%0d] got=%h exp=%h", k, sw.seg_out, es); end
        end
    endtask

    task automatic test_same_cycle();
        press(B_START);
        sw.count_down = 1'b0;
        press(B_LAP);
        press(B_START);
        idle(17);
        press(B_LAP);
        idle(5);
        press(B_START | B_LAP);
        total++; if (sw.running !== 1'b0 || sw.lap_count !== 3'd1)
            begin bad++; $display("FAIL same_cycle got run=%b laps=%0d exp run=0 laps=1", sw.running, sw.lap_count); end
    endtask

    task automatic test_random();
        bit [2:0] req;
        logic [41:0] es;
        do_reset();
        for (int c = 0; c < 4000 && bad < 40; c++) begin
            req = 3'b000;
            if ($urandom_range(0, 59) == 0) req[0] = 1'b1;
            if ($urandom_range(0, 14) == 0) req[1] = 1'b1;
            if ($urandom_range(0, 19) == 0) req[2] = 1'b1;
            if ($urandom_range(0, 199) == 0) sw.count_down = ~sw.count_down;
            if ($urandom_range(0, 99) == 0)
                sw.preset_bcd = ($urandom_range(0, 3) == 0) ? 24'($urandom) : {16'h0, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 12))};
            step(req);
            es = exp_seg();
            total++; if (sw.time_bcd !== to_bcd(m_cs)) begin bad++; $display("FAIL rnd_time c=%0d got=%h exp=%h", c, sw.time_bcd, to_bcd(m_cs)); end
            total++; if (sw.running !== (m_state == ST_RUN)) begin bad++; $display("FAIL rnd_running c=%0d got=%b exp=%b", c, sw.running, m_state == ST_RUN); end
            total++; if (sw.done !== (m_state == ST_DONE)) begin bad++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, sw.done, m_state == ST_DONE); end
            total++; if (sw.overflow_flag !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, sw.overflow_flag, m_ovf); end
            total++; if (sw.CLK_ind !== m_clk) begin bad++; $display("FAIL rnd_clk_ind c=%0d got=%b exp=%b", c, sw.CLK_ind, m_clk); end
            total++; if (sw.lap_count !== 3'(m_laps.size())) begin bad++; $display("FAIL rnd_lap_count c=%0d got=%0d exp=%0d", c, sw.lap_count, m_laps.size()); end
            total++; if (sw.lap_full !== (m_laps.size() == DEPTH)) begin bad++; $display("FAIL rnd_lap_full c=%0d got=%b exp=%b", c, sw.lap_full, m_laps.size() == DEPTH); end
            total++; if (sw.showing_lap !== (m_idx >= 0)) begin bad++; $display("FAIL rnd_showing c=%0d got=%b exp=%b", c, sw.showing_lap, m_idx >= 0); end
            total++; if (sw.seg_out !== es) begin bad++; $display("FAIL rnd_seg c=%0d got=%h exp=%h", c, sw.seg_out, es); end
        end
    endtask

    task automatic test_reset_mid();
        logic [41:0] zero_seg;
        zero_seg = {6{7'b1000000}};
        sw.count_down = 1'b0;
        press(B_START);
        if (m_state != ST_RUN) press(B_START);
        press(B_LAP);
        press(B_LAP);
        idle(3);
        press(B_RECALL);
        for (int i = 0; i < DIV && m_presc != DIV - 1; i++) step(3'b000);
        #2 rst_n = 1'b0;
        #1;
        total++; if (sw.lap_count !== 3'd0 || sw.time_bcd !== 24'h0)
            begin bad++; $display("FAIL mid_reset_counts got laps=%0d time=%h exp 0 000000", sw.lap_count, sw.time_bcd); end
        total++; if ({sw.running, sw.done, sw.overflow_flag, sw.CLK_ind, sw.lap_full, sw.showing_lap} !== 6'b0)
            begin bad++; $display("FAIL mid_reset_flags got=%b exp=000000", {sw.running, sw.done, sw.overflow_flag, sw.CLK_ind, sw.lap_full, sw.showing_lap}); end
        total++; if (sw.seg_out !== zero_seg) begin bad++; $display("FAIL mid_reset_seg got=%h exp=%h", sw.seg_out, zero_seg); end
        @(negedge clk);
        do_reset();
    endtask

    initial begin
        sw.start_stop = 1'b1;
        sw.lap_n      = 1'b1;
        sw.recall_n   = 1'b1;
        sw.count_down = 1'b0;
        sw.preset_bcd = 24'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_count_up();
        test_wrap();
        test_countdown();
        test_laps();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
